// File: rtl/pipe_stage.sv
// pipe_stage: one-deep valid/ready pipeline register with flush and a
// saturating backpressure counter.
// Optional feature macro: PIPE_STAGE_SKID_EN adds a skid entry so that
// in_ready is registered and has no combinational path from out_ready.
module pipe_stage #(
    parameter int unsigned          DATA_W   = 16,
    parameter int unsigned          CNT_W    = 8,
    parameter logic [DATA_W-1:0]    NOP_DATA = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              main_vld;
    logic [DATA_W-1:0] main_dat;
    logic              in_xfer;
    logic              out_xfer;

    assign out_valid = main_vld;
    assign out_data  = main_vld ? main_dat : NOP_DATA;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = main_vld && out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_vld;
    logic [DATA_W-1:0] skid_dat;
    logic              rdy_q;
    logic              main_vld_n;
    logic [DATA_W-1:0] main_dat_n;
    logic              skid_vld_n;
    logic [DATA_W-1:0] skid_dat_n;

    // in_ready comes from a flop; rst only gates it so it reads 0 during reset
    assign in_ready = rdy_q && !rst;

    // Next-state for main/skid entries; skid drains into main on an output transfer
    always_comb begin
        main_vld_n = main_vld;
        main_dat_n = main_dat;
        skid_vld_n = skid_vld;
        skid_dat_n = skid_dat;
        if (flush) begin
            main_vld_n = 1'b0;
            skid_vld_n = 1'b0;
        end else if (out_xfer) begin
            if (skid_vld) begin
                main_dat_n = skid_dat;
                if (in_xfer) begin
                    skid_dat_n = in_data;
                end else begin
                    skid_vld_n = 1'b0;
                end
            end else if (in_xfer) begin
                main_dat_n = in_data;
            end else begin
                main_vld_n = 1'b0;
            end
        end else if (in_xfer) begin
            if (main_vld) begin
                skid_vld_n = 1'b1;
                skid_dat_n = in_data;
            end else begin
                main_vld_n = 1'b1;
                main_dat_n = in_data;
            end
        end
    end

    // Entry registers and registered ready (ready == skid entry empty)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_vld <= 1'b0;
            main_dat <= '0;
            skid_vld <= 1'b0;
            skid_dat <= '0;
            rdy_q    <= 1'b1;
        end else begin
            main_vld <= main_vld_n;
            main_dat <= main_dat_n;
            skid_vld <= skid_vld_n;
            skid_dat <= skid_dat_n;
            rdy_q    <= !skid_vld_n;
        end
    end
`else
    // Single entry: accept when empty or when the held payload leaves this edge
    assign in_ready = (!main_vld || out_ready) && !rst;

    // Entry register; flush wins over both transfers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_vld <= 1'b0;
            main_dat <= '0;
        end else if (flush) begin
            main_vld <= 1'b0;
        end else if (in_xfer) begin
            main_vld <= 1'b1;
            main_dat <= in_data;
        end else if (out_xfer) begin
            main_vld <= 1'b0;
        end
    end
`endif

    // Saturating count of cycles where a valid payload is backpressured
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (main_vld && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage.sv
// tb_pipe_stage: directed self-checking bench for pipe_stage.
// Build with PIPE_STAGE_SKID_EN defined to also exercise the skid entry.
module tb_pipe_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        out_ready = 1'b0;
    logic        flush = 1'b0;

    logic        in_ready, out_valid;
    logic [15:0] out_data;
    logic [7:0]  stall_cnt;

    logic        in_ready3, out_valid3;
    logic [15:0] out_data3;
    logic [2:0]  stall_cnt3;

    int unsigned n_chk = 0;
    int unsigned n_bad = 0;

    pipe_stage #(.DATA_W(16), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .flush(flush), .stall_cnt(stall_cnt)
    );

    pipe_stage #(.DATA_W(16), .CNT_W(3)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3),
        .in_data(in_data), .out_valid(out_valid3), .out_ready(out_ready),
        .out_data(out_data3), .flush(flush), .stall_cnt(stall_cnt3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_ovld", 32'(out_valid), 32'd0);
        check("rst_odat", 32'(out_data), 32'h0);
        check("rst_cnt", 32'(stall_cnt), 32'd0);
        check("rst_irdy", 32'(in_ready), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_irdy", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #2;
        tick();
        do_reset();

        // single payload, 1-cycle latency
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h1234;
        #1;
        check("pre_odat", 32'(out_data), 32'h0);
        check("pre_ovld", 32'(out_valid), 32'd0);
        tick();
        check("lat_ovld", 32'(out_valid), 32'd1);
        check("lat_odat", 32'(out_data), 32'h1234);
        in_valid = 1'b0;
        tick();
        check("drain_ovld", 32'(out_valid), 32'd0);

        // back-to-back stream 1..16
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(i);
            #1;
            check("strm_irdy", 32'(in_ready), 32'd1);
            tick();
            check("strm_ovld", 32'(out_valid), 32'd1);
            check("strm_odat", 32'(out_data), 32'(i));
        end
        in_valid = 1'b0;
        tick();
        check("strm_end", 32'(out_valid), 32'd0);
        check("strm_cnt", 32'(stall_cnt), 32'd0);

        // 5-cycle stall with stable data
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h5555;
        tick();
        in_valid = 1'b0;
        in_data  = 16'h0bad;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("stall_odat", 32'(out_data), 32'h5555);
            check("stall_cnt", 32'(stall_cnt), 32'(i));
        end
`ifdef PIPE_STAGE_SKID_EN
        check("stall_irdy", 32'(in_ready), 32'd1);
`else
        check("stall_irdy", 32'(in_ready), 32'd0);
`endif
        out_ready = 1'b1;
        tick();
        check("unstall_ovld", 32'(out_valid), 32'd0);
        check("unstall_cnt", 32'(stall_cnt), 32'd5);

        // flush beats a simultaneous input transfer
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h1111;
        tick();
        out_ready = 1'b1;
        flush     = 1'b1;
        in_data   = 16'hBEEF;
        #1;
        check("flush_irdy", 32'(in_ready), 32'd1);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_ovld", 32'(out_valid), 32'd0);
        check("flush_odat", 32'(out_data), 32'h0);
        check("flush_cnt", 32'(stall_cnt), 32'd5);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("no_beef", 32'(out_valid || (out_data == 16'hBEEF)), 32'd0);
        end

        // reset mid-operation drops the held payload asynchronously
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h2222;
        tick();
        tick();
        check("pre_rst_ovld", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        do_reset();
        tick();
        check("rst_drop", 32'(out_valid), 32'd0);

        // 10-cycle stall: 8-bit counter reaches 10, 3-bit saturates at 7
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h7777;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("sat8_cnt", 32'(stall_cnt), 32'd10);
        check("sat3_cnt", 32'(stall_cnt3), 32'd7);
        check("sat3_odat", 32'(out_data3), 32'h7777);
        out_ready = 1'b1;
        tick();
        check("sat3_hold", 32'(stall_cnt3), 32'd7);

`ifdef PIPE_STAGE_SKID_EN
        // skid entry absorbs a second payload under backpressure
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h000A;
        tick();
        check("skid_irdy1", 32'(in_ready), 32'd1);
        in_data = 16'h000B;
        tick();
        in_valid = 1'b0;
        check("skid_irdy0", 32'(in_ready), 32'd0);
        check("skid_hold", 32'(out_data), 32'h000A);
        out_ready = 1'b1;
        #1;
        check("skid_irdy_reg", 32'(in_ready), 32'd0);
        tick();
        check("skid_b", 32'(out_data), 32'h000B);
        check("skid_irdy_back", 32'(in_ready), 32'd1);
        tick();
        check("skid_empty", 32'(out_valid), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the payload width in bits.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the stall-counter width in bits.
REQ-003 The block SHALL have parameter NOP_DATA, default all-zeros of DATA_W, giving the value driven on out_data while out_valid is 0.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the upstream stage offers in_data.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the stage can accept a payload this cycle.
REQ-008 The block SHALL have port in_data, input, DATA_W bits: the upstream payload.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_data holds a valid payload.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the downstream stage accepts out_data.
REQ-011 The block SHALL have port out_data, output, DATA_W bits: the downstream payload.
REQ-012 The block SHALL have port flush, input, 1 bit: discard all held payloads (branch/redirect).
REQ-013 The block SHALL have port stall_cnt, output, CNT_W bits: count of backpressured cycles.

Function
REQ-014 An input transfer SHALL occur on an edge with in_valid=1 and in_ready=1; an output transfer SHALL occur on an edge with out_valid=1 and out_ready=1.
REQ-015 Payloads SHALL leave in acceptance order, with none lost or duplicated except by flush.
REQ-016 Once asserted, out_valid SHALL remain 1, and out_data SHALL remain stable, until an output transfer or a flush occurs.
REQ-017 Input-to-output latency SHALL be 1 cycle: data accepted at edge N appears on out_data after edge N when the stage was empty.
REQ-018 With flush=1 at an edge, all held entries SHALL be invalidated; an input transfer on that same edge SHALL be discarded; out_valid SHALL be 0 in the following cycle.
REQ-019 Flush SHALL take priority over any simultaneous input or output transfer.
REQ-020 While out_valid is 0, out_data SHALL equal NOP_DATA.
REQ-021 stall_cnt SHALL increment by 1 on every edge with out_valid=1 and out_ready=0, saturating at 2^CNT_W-1 (no wrap).
REQ-022 stall_cnt SHALL be unaffected by flush.
REQ-023 With equal-length simultaneous input and output transfers at full occupancy, the stage SHALL sustain one payload per cycle.

Reset
REQ-024 While rst=1, asynchronously and regardless of clk: out_valid=0, out_data=NOP_DATA, stall_cnt=0, and all internal valid bits are cleared.
REQ-025 in_ready SHALL be 0 while rst=1 and SHALL be 1 in the first cycle after rst deasserts.
REQ-026 Reset asserted mid-operation SHALL discard all held payloads; no transfer SHALL complete on the edge at which rst is sampled high.

Configuration
REQ-027 With macro PIPE_STAGE_SKID_EN undefined, the stage SHALL hold one entry, with combinational in_ready = (!out_valid || out_ready) && !rst.
REQ-028 With PIPE_STAGE_SKID_EN defined, the stage SHALL hold a main entry plus one skid entry, and in_ready SHALL be a register output equal to "skid entry empty".
REQ-029 In skid mode, a payload accepted while the main entry is occupied and out_ready=0 SHALL go to the skid entry, and SHALL move to the main entry on the next output transfer.
REQ-030 In skid mode, in_ready SHALL have no combinational path from out_ready.
REQ-031 In skid mode, capacity SHALL be 2 and full throughput SHALL be preserved.

Verification
REQ-032 Reset, then in_valid=1 with data 0x1234 and out_ready=1 -> out_valid=1 and out_data=0x1234 one cycle later; out_data=0x0000 before that.
REQ-033 Stream 0x0001..0x0010 with out_ready=1 throughout -> 16 consecutive output transfers in order, with in_ready held at 1.
REQ-034 Hold out_ready=0 for 5 cycles with data pending -> out_data stable, stall_cnt=5; then out_ready=1 -> transfer completes and stall_cnt stays 5.
REQ-035 flush=1 together with in_valid=1 carrying 0xBEEF -> out_valid=0 the next cycle and 0xBEEF never appears at the output.
REQ-036 With CNT_W=3, hold a stall for 10 cycles -> stall_cnt saturates at 7.
REQ-037 With PIPE_STAGE_SKID_EN, out_ready=0 and two inputs 0xA, 0xB offered -> both accepted, then in_ready=0; release out_ready -> outputs 0xA then 0xB.
